// File: rtl/muldiv_pkg.sv
// Shared encodings for the HI/LO multiply/divide sequencer.
package muldiv_pkg;

    localparam int MD_WIDTH = 32;
    localparam int CNT_W    = $clog2(MD_WIDTH);

    typedef enum logic [1:0] {
        OP_MULTU = 2'b00,
        OP_MULT  = 2'b01,
        OP_DIVU  = 2'b10,
        OP_DIV   = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIX  = 2'b10
    } state_e;

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add multiply or restoring divide on a 2*WIDTH accumulator.
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   opnd,
    input  logic               div_mode,
    output logic [2*WIDTH-1:0] acc_next
);

    logic [WIDTH-1:0] addend;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   trial;

    always_comb begin
        addend = acc[0] ? opnd : {WIDTH{1'b0}};
        sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, addend};
        // Shifted remainder needs WIDTH+1 bits; the top bit of the difference is the borrow.
        trial  = acc[2*WIDTH-1:WIDTH-1] - {1'b0, opnd};
        if (div_mode) begin
            if (!trial[WIDTH]) begin
                acc_next = {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            end else begin
                acc_next = {acc[2*WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_next = {sum, acc[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle MIPS HI/LO multiply/divide sequencer: one iteration per clock,
// sign fix-up at the end, and stall generation for HI/LO accesses while busy.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    input  logic             hi_re,
    input  logic             lo_re,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             stall
);

    localparam int CW = $clog2(WIDTH);

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d, acc_step;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [WIDTH-1:0]   dvd_q, dvd_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic               is_div_q, is_div_d;
    logic               res_neg_q, res_neg_d;
    logic               a_neg_q, a_neg_d;
    logic               done_q, done_d;

    logic               signed_op, a_neg, b_neg;
    logic [WIDTH-1:0]   a_abs, b_abs, quo_fix, rem_fix;
    logic [2*WIDTH-1:0] prod_fix;

    assign signed_op = (op == OP_MULT) || (op == OP_DIV);
    assign a_neg     = signed_op & a[WIDTH-1];
    assign b_neg     = signed_op & b[WIDTH-1];
    assign a_abs     = a_neg ? -a : a;
    assign b_abs     = b_neg ? -b : b;

    // Remainder follows the dividend's sign; quotient/product follow the XOR of signs.
    assign prod_fix  = res_neg_q ? -acc_q : acc_q;
    assign quo_fix   = res_neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign rem_fix   = a_neg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .acc      (acc_q),
        .opnd     (opnd_q),
        .div_mode (is_div_q),
        .acc_next (acc_step)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        dvd_d     = dvd_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        is_div_d  = is_div_q;
        res_neg_d = res_neg_q;
        a_neg_d   = a_neg_q;
        done_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    is_div_d  = op[1];
                    opnd_d    = op[1] ? b_abs : a_abs;
                    acc_d     = {{WIDTH{1'b0}}, (op[1] ? a_abs : b_abs)};
                    dvd_d     = a;
                    res_neg_d = a_neg ^ b_neg;
                    a_neg_d   = a_neg;
                    cnt_d     = '0;
                    state_d   = RUN;
                end else begin
                    if (hi_we) hi_d = wdata;
                    if (lo_we) lo_d = wdata;
                end
            end
            RUN: begin
                acc_d = acc_step;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) state_d = FIX;
            end
            FIX: begin
                if (is_div_q) begin
                    // Divide by zero: all-ones quotient, dividend passed through as remainder.
                    if (opnd_q == '0) begin
                        lo_d = '1;
                        hi_d = dvd_q;
                    end else begin
                        lo_d = quo_fix;
                        hi_d = rem_fix;
                    end
                end else begin
                    {hi_d, lo_d} = prod_fix;
                end
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        acc_q     <= acc_d;
        opnd_q    <= opnd_d;
        dvd_q     <= dvd_d;
        is_div_q  <= is_div_d;
        res_neg_q <= res_neg_d;
        a_neg_q   <= a_neg_d;
    end

    assign hi    = hi_q;
    assign lo    = lo_q;
    assign busy  = (state_q != IDLE);
    assign done  = done_q;
    assign stall = busy & (start | hi_re | lo_re | hi_we | lo_we);

endmodule
